// File: rtl/elastic_pipeline_pkg.sv
// Shared parameters and helpers for the elastic pipeline.
// ELASTIC_PIPELINE_SKID_EN widens occupancy to cover the extra input skid entry.
package elastic_pipeline_pkg;

    localparam int unsigned STAGES_MIN = 1;
    localparam int unsigned STAGES_MAX = 64;

    // Occupancy counter width: enough to count every beat the block can hold.
    function automatic int unsigned occ_width(input int unsigned stages);
`ifdef ELASTIC_PIPELINE_SKID_EN
        return $clog2(stages + 2);
`else
        return $clog2(stages + 1);
`endif
    endfunction

endpackage

// File: rtl/elastic_pipeline_skid_buffer.sv
// Input skid buffer: pass-through when empty, one holding register when the
// consumer stalls, so s_ready comes straight from a flop.
module skid_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic                  full_q;
    logic [DATA_WIDTH-1:0] hold_q;

    assign s_ready = ~full_q;
    assign m_valid = full_q | s_valid;
    assign m_data  = full_q ? hold_q : s_data;

    // Capture a beat only when it was offered and the consumer refused it.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || flush_in) begin
            full_q <= 1'b0;
        end else if (full_q) begin
            if (m_ready) begin
                full_q <= 1'b0;
            end
        end else if (s_valid && !m_ready) begin
            full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!full_q && s_valid && !m_ready) begin
            hold_q <= s_data;
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// Bubble-collapsing valid/ready register pipeline with flush and occupancy.
// Define ELASTIC_PIPELINE_SKID_EN to register s_ready behind an input skid buffer.
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int unsigned STAGES     = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    input  logic                         flush_in,
    output logic [occ_width(STAGES)-1:0] occupancy
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("elastic_pipeline: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
    end

    logic                  run;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [STAGES-1:0]     valid_q;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [STAGES-1:0]     rdy_c;
    logic                  all_full;
    logic                  up;
    logic                  down;
    logic [OCC_W-1:0]      occ_q;

    assign run = rst_n_in & ~flush_in;

`ifdef ELASTIC_PIPELINE_SKID_EN
    logic skid_s_ready;

    skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .flush_in(flush_in),
        .s_data  (s_data),
        .s_valid (s_valid & run),
        .s_ready (skid_s_ready),
        .m_data  (in_data),
        .m_valid (in_valid),
        .m_ready (rdy_c[0])
    );

    assign s_ready = skid_s_ready & run;
`else
    assign s_ready  = rdy_c[0] & run;
    assign in_valid = s_valid & s_ready;
    assign in_data  = s_data;
`endif

    // Stage i may load when any stage at or beyond it is empty, or the sink takes.
    always_comb begin
        all_full = 1'b1;
        rdy_c    = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            all_full = all_full & valid_q[i];
            rdy_c[i] = m_ready | ~all_full;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!run) begin
            valid_q <= '0;
        end else begin
            if (rdy_c[0]) begin
                valid_q[0] <= in_valid;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (rdy_c[i]) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end
    end

    // Payload registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk_in) begin
        if (rdy_c[0]) begin
            data_q[0] <= in_data;
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            if (rdy_c[i]) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign m_valid = valid_q[STAGES-1];
    assign m_data  = data_q[STAGES-1];

    assign up   = s_valid & s_ready;
    assign down = m_valid & m_ready;

    // Beats held = accepted minus delivered; flush and reset empty everything.
    always_ff @(posedge clk_in) begin
        if (!run) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(up) - OCC_W'(down);
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed and randomised checks of elastic_pipeline (STAGES=4, DATA_WIDTH=32).
// Builds with or without ELASTIC_PIPELINE_SKID_EN.
module tb_elastic_pipeline;
    import elastic_pipeline_pkg::*;

    localparam int STAGES = 4;
    localparam int DW     = 32;
    localparam int OW     = occ_width(STAGES);
`ifdef ELASTIC_PIPELINE_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          flush_in;
    logic [OW-1:0] occupancy;

    int errors = 0;
    int checks = 0;

    int            idx;
    int            acc;
    int            del;
    int            exp_v;
    int            delivered;
    int            cyc;
    logic          hold;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] q [$];

    elastic_pipeline #(
        .STAGES    (STAGES),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .flush_in (flush_in),
        .occupancy(occupancy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive_slot();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample_slot();
        @(negedge clk_in);
    endtask

    task automatic score_slot();
        if (prev_stall) begin
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_data", m_data, prev_data);
        end
        if (s_valid && s_ready) begin
            q.push_back(s_data);
            hold = 1'b0;
        end else begin
            hold = s_valid;
        end
        if (m_valid && m_ready) begin
            chk("sb_beat_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("sb_data", m_data, q[0]);
                void'(q.pop_front());
            end
            delivered++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    initial begin
        rst_n_in = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        flush_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in);
        sample_slot();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_s_ready", s_ready, 0);
        drive_slot();
        rst_n_in = 1'b1;
        sample_slot();
        chk("post_rst_s_ready", s_ready, 1);

        // Stream 1..16 with m_ready high: beat presented in slot n leaves in slot n+STAGES
        for (int n = 0; n < 16 + STAGES + 2; n++) begin
            drive_slot();
            m_ready = 1'b1;
            s_valid = (n < 16);
            s_data  = DW'(n + 1);
            sample_slot();
            exp_v = (n >= STAGES && n - STAGES < 16) ? 1 : 0;
            chk("stream_m_valid", m_valid, exp_v);
            if (exp_v != 0) chk("stream_m_data", m_data, n - STAGES + 1);
            acc = (n < 16) ? n : 16;
            del = n - STAGES;
            if (del < 0) del = 0;
            if (del > 16) del = 16;
            chk("stream_occupancy", occupancy, acc - del);
            if (n < 16) chk("stream_s_ready", s_ready, 1);
        end

        // Backpressure: push 6 beats with m_ready low
        idx = 0;
        for (int n = 0; n < 8; n++) begin
            drive_slot();
            m_ready = 1'b0;
            s_valid = (idx < 6);
            s_data  = DW'(32'h100 + idx);
            sample_slot();
            if (s_valid && s_ready) idx++;
        end
        chk("bp_accepted", idx, STAGES + SKID);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_occupancy", occupancy, STAGES + SKID);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, 32'h100);

        // Release: every beat delivered in order with no gap
        for (int n = 0; n < 10; n++) begin
            drive_slot();
            m_ready = 1'b1;
            s_valid = (idx < 6);
            s_data  = DW'(32'h100 + idx);
            sample_slot();
            if (n == 0) chk("release_s_ready", s_ready, (SKID != 0) ? 0 : 1);
            if (n < 6) begin
                chk("drain_m_valid", m_valid, 1);
                chk("drain_m_data", m_data, 32'h100 + n);
            end
            if (s_valid && s_ready) idx++;
        end
        chk("drain_all_accepted", idx, 6);
        chk("drain_empty_m_valid", m_valid, 0);
        chk("drain_empty_occupancy", occupancy, 0);

        // Flush with three beats in flight and a concurrent upstream beat
        for (int n = 0; n < 3; n++) begin
            drive_slot();
            m_ready = 1'b0;
            s_valid = 1'b1;
            s_data  = DW'(32'h200 + n);
            sample_slot();
            chk("flush_fill_s_ready", s_ready, 1);
        end
        drive_slot();
        s_valid  = 1'b1;
        s_data   = 32'h2FF;
        flush_in = 1'b1;
        m_ready  = 1'b1;
        sample_slot();
        chk("flush_occ_before", occupancy, 3);
        chk("flush_s_ready_low", s_ready, 0);
        drive_slot();
        flush_in = 1'b0;
        s_valid  = 1'b0;
        sample_slot();
        chk("flush_m_valid", m_valid, 0);
        chk("flush_occupancy", occupancy, 0);
        for (int n = 0; n < 8; n++) begin
            drive_slot();
            sample_slot();
            chk("flush_no_ghost", m_valid, 0);
        end

        // Reset mid-stream, then 0xA5 travels the full pipeline
        for (int n = 0; n < 2; n++) begin
            drive_slot();
            m_ready = 1'b1;
            s_valid = 1'b1;
            s_data  = DW'(32'h300 + n);
            sample_slot();
        end
        drive_slot();
        rst_n_in = 1'b0;
        sample_slot();
        chk("midrst_s_ready", s_ready, 0);
        drive_slot();
        rst_n_in = 1'b1;
        s_valid  = 1'b1;
        s_data   = 32'hA5;
        sample_slot();
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_occupancy", occupancy, 0);
        chk("a5_s_ready", s_ready, 1);
        for (int k = 1; k <= STAGES; k++) begin
            drive_slot();
            s_valid = 1'b0;
            sample_slot();
            if (k == 1) chk("a5_occupancy", occupancy, 1);
            if (k < STAGES) begin
                chk("a5_not_yet", m_valid, 0);
            end else begin
                chk("a5_m_valid", m_valid, 1);
                chk("a5_m_data", m_data, 32'hA5);
            end
        end

        // Random valid/ready traffic against a scoreboard
        drive_slot();
        m_ready = 1'b1;
        sample_slot();
        q.delete();
        delivered  = 0;
        cyc        = 0;
        hold       = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (delivered < 1000 && cyc < 20000) begin
            drive_slot();
            m_ready = 1'($urandom_range(0, 1));
            if (!hold) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = DW'($urandom);
            end
            sample_slot();
            score_slot();
            cyc++;
        end
        chk("rand_delivered", delivered, 1000);
        for (int n = 0; n < STAGES + 6; n++) begin
            drive_slot();
            s_valid = 1'b0;
            m_ready = 1'b1;
            sample_slot();
            score_slot();
        end
        chk("rand_drained", q.size(), 0);
        chk("rand_final_occupancy", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
